printf_decimal_formatter: RTL and testbench
===========================================

Name: printf_decimal_formatter

Overview:
- Downstream consumer of the free-running debug counter, the value its printf statement reports.
- Accepts one unsigned binary sample per handshake and converts it to decimal with a sequential shift-add-3 (double-dabble) engine.
- Streams the result as ASCII characters with leading zeros suppressed, terminated by a newline (0x0A).
- Feeds the simulation/debug character sink (UART or trace buffer) through a valid/ready byte interface.

Parameters:
- WIDTH, 10, bit width of the input sample (matches the 10-bit counter).
- DIGITS, 4, number of BCD digits held. Must be >= number of decimal digits of 2^WIDTH-1; the default holds 1023.

Ports:
- clock, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset. Asserted (0) forces all state to reset values immediately; release is synchronous to clock.
- in_valid, input, 1, sample offered.
- in_ready, output, 1, block can accept a sample (high only in IDLE).
- in_data, input, WIDTH, unsigned sample.
- out_valid, output, 1, character available.
- out_ready, input, 1, sink accepts the character.
- out_data, output, 8, ASCII character.
- out_last, output, 1, marks the final character (newline) of a message.
- busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset values: state=IDLE, in_ready=1 after release (0 while reset is low), out_valid=0, out_data=0x00, out_last=0, busy=0, internal shift/BCD registers cleared.
- Input handshake: a transfer occurs on an edge where in_valid & in_ready. in_data is captured into a WIDTH-bit shift register and the BCD register (4*DIGITS bits) is cleared. in_valid while busy is ignored and no sample is queued.
- States and transitions:
  - IDLE: in_ready=1. Goes to CONVERT on input transfer.
  - CONVERT: exactly WIDTH cycles, tracked by an iteration counter of ceil(log2(WIDTH+1)) bits. Each cycle, every BCD nibble >= 5 gets +3 (4-bit add, no carry out of the nibble), then {bcd, shift} shifts left by 1 with the shift MSB entering the BCD LSB. After the WIDTH-th iteration, goes to LOCATE.
  - LOCATE: one cycle. Sets the digit index to the most significant nonzero nibble; index 0 if all nibbles are zero, so value 0 prints "0". Goes to EMIT.
  - EMIT: out_valid=1, out_data=0x30+nibble[index], out_last=0. On out_valid & out_ready: if index=0 go to EOL, else decrement the index. Interior zeros are printed.
  - EOL: out_valid=1, out_data=0x0A, out_last=1. On handshake goes to IDLE; in_ready rises the following cycle.
- Latency: if the input transfer is at edge E, CONVERT occupies the WIDTH cycles after E, LOCATE the next cycle, and out_valid first rises WIDTH+2 cycles after E (12 for the default).
- Output handshake rule: while out_valid=1 and out_ready=0, out_data and out_last hold stable. out_valid never drops without a transfer. out_ready has no combinational path to out_valid.
- out_ready is ignored when out_valid=0.
- Throughput: back-to-back messages are allowed. Minimum per message is WIDTH+2 + (digits+1) cycles plus 1 IDLE cycle.
- Reset mid-operation: the message is aborted, no partial newline is emitted, and the block restarts in IDLE with nothing pending.
- in_data above 10^DIGITS-1 is impossible by the parameter constraint. A bench check that flags a constraint violation is permitted.

Test Plan:
- Reset low for 3 cycles, then release -> in_ready=1, out_valid=0, busy=0. Reset asserted mid-cycle clears outputs without waiting for a clock edge.
- in_data=0, out_ready=1 -> stream 0x30, 0x0A; out_last only on 0x0A; first out_valid 12 cycles after the input transfer.
- in_data=1023 -> 0x31, 0x30, 0x32, 0x33, 0x0A. in_data=100 -> 0x31, 0x30, 0x30, 0x0A (interior zeros kept). in_data=7 -> 0x37, 0x0A.
- Backpressure: in_data=42 with out_ready toggled 0,0,1,0,1,1 -> out_data holds 0x34 until accepted, then 0x32, then 0x0A; no character lost or duplicated.
- Second in_valid pulse with in_data=5 during CONVERT of 999 -> ignored (in_ready=0); output is exactly "999\n"; a subsequent sample of 5 after IDLE yields "5\n".
- Reset asserted while EMIT is showing the second digit of 1023 -> out_valid=0 immediately; after release a new sample of 8 produces only "8\n".

Source files
------------

// File: rtl/printf_decimal_formatter.sv
// -----------------------------------------------------------------------------
// printf_decimal_formatter
//
// Takes one unsigned binary sample per input handshake and turns it into a
// decimal ASCII line for the debug character sink. The value is converted with
// a sequential shift-add-3 (double-dabble) engine. Leading zeros are dropped
// and the line ends with a newline (0x0A), which is flagged with out_last.
//
// Ports
//   clock      : sole clock, rising edge
//   reset      : asynchronous active-low reset, released synchronously
//   in_valid   : sample offered
//   in_ready   : block can take a sample (high only while idle)
//   in_data    : WIDTH-bit unsigned sample
//   out_valid  : ASCII character available
//   out_ready  : sink accepts the character
//   out_data   : ASCII character
//   out_last   : final character (newline) of the line
//   busy       : any state other than idle
//   state_dbg  : current FSM state encoding, for checkers
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid and ready are both high. Once out_valid is high it stays high,
// with out_data/out_last frozen, until the transfer; out_valid never depends
// combinationally on out_ready. in_valid while busy is dropped, not queued.
//
// Parameters
//   WIDTH  : sample width (10 for the debug counter)
//   DIGITS : BCD digits held; must cover 2^WIDTH-1 (4 digits hold 1023)
// -----------------------------------------------------------------------------
module printf_decimal_formatter #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_LOCATE  = 3'd2,
    S_EMIT    = 3'd3,
    S_EOL     = 3'd4
  } state_t;

  state_t                 state;
  logic [WIDTH-1:0]       shift_q;
  logic [BCDW-1:0]        bcd_q;
  logic [CNTW-1:0]        iter_q;
  logic [IDXW-1:0]        idx_q;

  logic [BCDW-1:0]        bcd_adj;
  logic [BCDW+WIDTH-1:0]  shifted;
  logic [IDXW-1:0]        top_idx;
  logic [IDXW-1:0]        idx_dec;

  assign state_dbg = state;

  // Add-3 step: every nibble >= 5 gets +3 before the shift, so it carries
  // correctly into the next decimal digit. The add wraps inside the nibble.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // {bcd, shift} moves left as one vector; the sample MSB enters the BCD LSB.
  assign shifted = {bcd_adj, shift_q} << 1;

  // Highest nonzero nibble. Stays 0 when every nibble is zero so that the
  // value 0 still prints a single "0".
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        top_idx = IDXW'(i);
      end
    end
  end

  assign idx_dec = idx_q - IDXW'(1);

  function automatic logic [7:0] digit_char(input logic [BCDW-1:0] bcd,
                                            input logic [IDXW-1:0] idx);
    return 8'h30 + {4'h0, bcd[4*idx +: 4]};
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      shift_q   <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      idx_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            shift_q  <= in_data;
            bcd_q    <= '0;
            iter_q   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_CONVERT;
          end else begin
            // in_ready comes up on the first edge after reset release
            in_ready <= 1'b1;
          end
        end

        S_CONVERT: begin
          bcd_q   <= shifted[BCDW+WIDTH-1:WIDTH];
          shift_q <= shifted[WIDTH-1:0];
          iter_q  <= iter_q + CNTW'(1);
          if (iter_q == CNTW'(WIDTH - 1)) begin
            state <= S_LOCATE;
          end
        end

        S_LOCATE: begin
          idx_q     <= top_idx;
          out_valid <= 1'b1;
          out_data  <= digit_char(bcd_q, top_idx);
          out_last  <= 1'b0;
          state     <= S_EMIT;
        end

        S_EMIT: begin
          if (out_ready) begin
            if (idx_q == '0) begin
              out_data <= 8'h0A;
              out_last <= 1'b1;
              state    <= S_EOL;
            end else begin
              // interior zeros are printed like any other digit
              idx_q    <= idx_dec;
              out_data <= digit_char(bcd_q, idx_dec);
            end
          end
        end

        S_EOL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          out_data  <= 8'h00;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_printf_decimal_formatter.sv
// -----------------------------------------------------------------------------
// tb_printf_decimal_formatter
//
// Directed and randomized stimulus for printf_decimal_formatter. Expected
// character streams come from a decimal model built with /10 and %10.
// -----------------------------------------------------------------------------
module tb_printf_decimal_formatter;

  localparam int WIDTH  = 10;
  localparam int DIGITS = 4;

  // ---------------- clock / reset ----------------
  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;
  logic [2:0]       state_dbg;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  printf_decimal_formatter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         base_cyc = 0;
  int         first_valid_cyc = -1;
  logic [7:0] exp_q[$];
  logic [7:0] got_d[$];
  bit         got_l[$];
  bit         stall_pending = 1'b0;
  logic [7:0] stall_data;
  logic       stall_last;
  bit         bp_pat[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of v, most significant first, then newline.
  task automatic model(input int v);
    int d[$];
    int x;
    x = v;
    exp_q.delete();
    if (x == 0) d.push_back(0);
    while (x > 0) begin
      d.push_front(x % 10);
      x = x / 10;
    end
    foreach (d[i]) exp_q.push_back(8'h30 + 8'(d[i]));
    exp_q.push_back(8'h0A);
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: sample outputs at the falling edge, return 1 time unit after
  // the next rising edge so the caller can drive new inputs.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (stall_pending) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, stall_data);
      check("hold_last", out_last, stall_last);
    end
    stall_pending = out_valid && !out_ready && reset;
    stall_data    = out_data;
    stall_last    = out_last;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int v);
    int budget;
    budget = 0;
    in_data  = WIDTH'(v);
    in_valid = 1'b1;
    while (!in_ready && budget < 100) begin
      tick();
      budget++;
    end
    check("send_ready", in_ready, 1);
    tick();
    base_cyc = cyc;
    first_valid_cyc = -1;
    in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: backpressure pattern
  task automatic collect(input int mode, input int stop_after, input bit inject);
    int budget;
    int p;
    bit done;
    budget = 0;
    p = 0;
    done = 1'b0;
    while (!done && budget < 400) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid) begin
            out_ready = (p < 6) ? bp_pat[p] : 1'b1;
            p++;
          end else begin
            out_ready = 1'b0;
          end
        end
      endcase
      if (inject && budget < 3) begin
        in_valid = 1'b1;
        in_data  = WIDTH'(5);
        check("ignored_in_ready", in_ready, 0);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      budget++;
      if (stop_after > 0 && got_d.size() >= stop_after) done = 1'b1;
      else if (got_l.size() > 0 && got_l[got_l.size()-1]) done = 1'b1;
    end
    in_valid = 1'b0;
    check("collect_timeout", done, 1);
  endtask

  task automatic compare_msg(input string tag);
    check({tag, "_len"}, got_d.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      check({tag, "_char"}, got_d[i], exp_q[i]);
      check({tag, "_last"}, got_l[i], (i == exp_q.size() - 1) ? 1 : 0);
    end
  endtask

  task automatic run_value(input int v, input int mode, input bit inject, input string tag);
    model(v);
    got_d.delete();
    got_l.delete();
    send(v);
    collect(mode, 0, inject);
    check({tag, "_latency"}, first_valid_cyc - base_cyc, WIDTH + 2);
    compare_msg(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_last", out_last, 0);

    reset = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);
    check("rel_busy", busy, 0);

    run_value(0, 0, 1'b0, "v0");
    run_value(1023, 0, 1'b0, "v1023");
    run_value(100, 0, 1'b0, "v100");
    run_value(7, 0, 1'b0, "v7");
    run_value(42, 2, 1'b0, "bp42");

    // sample offered during conversion is dropped
    run_value(999, 0, 1'b1, "v999_ign");
    tick();
    check("after999_in_ready", in_ready, 1);
    repeat (4) tick();
    check("after999_no_msg", out_valid, 0);
    check("after999_no_chars", got_d.size(), exp_q.size());
    run_value(5, 0, 1'b0, "v5");

    // reset while the second digit of 1023 is on the output
    model(1023);
    got_d.delete();
    got_l.delete();
    send(1023);
    collect(0, 1, 1'b0);
    check("mid_first_char", got_d[0], 8'h31);
    check("mid_emit2_valid", out_valid, 1);
    check("mid_emit2_data", out_data, 8'h30);
    #2;
    reset = 1'b0;
    stall_pending = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_data", out_data, 8'h00);
    check("async_out_last", out_last, 0);
    check("async_busy", busy, 0);
    check("async_in_ready", in_ready, 0);
    repeat (2) tick();
    got_d.delete();
    got_l.delete();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rel2_in_ready", in_ready, 1);
    repeat (3) tick();
    check("no_partial_eol", got_d.size(), 0);
    run_value(8, 0, 1'b0, "v8");

    // randomized back-to-back samples with random sink readiness
    for (int n = 0; n < 20; n++) begin
      v = int'($urandom_range(0, (1 << WIDTH) - 1));
      run_value(v, 1, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
